// File: rtl/sched_src_queue.sv
// sched_src_queue: eight per-channel FIFOs fed from one push port, each draining over valid/ready
module sched_src_queue #(
   parameter int DEPTH = 4,
   parameter int DW = 8,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic [2:0]    push_ch_i,
   input  logic [DW-1:0] push_data_i,
   input  logic [PW-1:0] push_prio_i,
   output logic          push_ready_o,
   output logic          valid_o_0,
   output logic          valid_o_1,
   output logic          valid_o_2,
   output logic          valid_o_3,
   output logic          valid_o_4,
   output logic          valid_o_5,
   output logic          valid_o_6,
   output logic          valid_o_7,
   output logic [DW-1:0] data_o_0,
   output logic [DW-1:0] data_o_1,
   output logic [DW-1:0] data_o_2,
   output logic [DW-1:0] data_o_3,
   output logic [DW-1:0] data_o_4,
   output logic [DW-1:0] data_o_5,
   output logic [DW-1:0] data_o_6,
   output logic [DW-1:0] data_o_7,
   output logic [PW-1:0] priority_o_0,
   output logic [PW-1:0] priority_o_1,
   output logic [PW-1:0] priority_o_2,
   output logic [PW-1:0] priority_o_3,
   output logic [PW-1:0] priority_o_4,
   output logic [PW-1:0] priority_o_5,
   output logic [PW-1:0] priority_o_6,
   output logic [PW-1:0] priority_o_7,
   input  logic          ready_i_0,
   input  logic          ready_i_1,
   input  logic          ready_i_2,
   input  logic          ready_i_3,
   input  logic          ready_i_4,
   input  logic          ready_i_5,
   input  logic          ready_i_6,
   input  logic          ready_i_7,
   output logic [15:0]   drop_cnt_o,
   output logic          busy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [AW-1:0] rd_q [8];
   logic [AW-1:0] rd_d [8];
   logic [AW-1:0] wr_q [8];
   logic [AW-1:0] wr_d [8];
   logic [AW:0]   cnt_q [8];
   logic [AW:0]   cnt_d [8];
   logic [DW-1:0] dmem_q [8][DEPTH];
   logic [PW-1:0] pmem_q [8][DEPTH];
   logic [DW-1:0] hd [8];
   logic [PW-1:0] hp [8];
   logic [15:0]   drop_q, drop_d;
   logic [7:0]    vld, rdy, pop, psh;
   logic          acc;

   assign rdy = {ready_i_7, ready_i_6, ready_i_5, ready_i_4, ready_i_3, ready_i_2, ready_i_1, ready_i_0};
   assign push_ready_o = cnt_q[push_ch_i] != FULL;
   assign acc = push_i && push_ready_o;
   assign busy_o = |vld;
   assign drop_cnt_o = drop_q;
   assign {valid_o_7, valid_o_6, valid_o_5, valid_o_4, valid_o_3, valid_o_2, valid_o_1, valid_o_0} = vld;
   assign data_o_0 = hd[0];
   assign data_o_1 = hd[1];
   assign data_o_2 = hd[2];
   assign data_o_3 = hd[3];
   assign data_o_4 = hd[4];
   assign data_o_5 = hd[5];
   assign data_o_6 = hd[6];
   assign data_o_7 = hd[7];
   assign priority_o_0 = hp[0];
   assign priority_o_1 = hp[1];
   assign priority_o_2 = hp[2];
   assign priority_o_3 = hp[3];
   assign priority_o_4 = hp[4];
   assign priority_o_5 = hp[5];
   assign priority_o_6 = hp[6];
   assign priority_o_7 = hp[7];

   // per-channel pointer/count update; heads are zeroed while empty so stale memory never leaks out
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         vld[i] = cnt_q[i] != '0;
         pop[i] = vld[i] && rdy[i];
         psh[i] = acc && push_ch_i == 3'(i);
         rd_d[i] = rd_q[i] + AW'(pop[i]);
         wr_d[i] = wr_q[i] + AW'(psh[i]);
         cnt_d[i] = cnt_q[i] + (AW+1)'(psh[i]) - (AW+1)'(pop[i]);
         hd[i] = vld[i] ? dmem_q[i][rd_q[i]] : '0;
         hp[i] = vld[i] ? pmem_q[i][rd_q[i]] : '0;
      end
      drop_d = (push_i && !push_ready_o && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end

   // control state; reset empties every channel at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            rd_q[i] <= '0;
            wr_q[i] <= '0;
            cnt_q[i] <= '0;
         end
         drop_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
         drop_q <= drop_d;
      end
   end

   // entry storage, deliberately left out of reset
   always_ff @(posedge clk) begin
      if (acc) begin
         dmem_q[push_ch_i][wr_q[push_ch_i]] <= push_data_i;
         pmem_q[push_ch_i][wr_q[push_ch_i]] <= push_prio_i;
      end
   end
endmodule

// File: tb/tb_sched_src_queue.sv
// tb_sched_src_queue: directed stimulus with per-channel scoreboard checked by a handshake monitor
module tb_sched_src_queue;
   logic       clk = 0;
   logic       reset_n = 0;
   logic       push = 0;
   logic [2:0] pch = 0;
   logic [7:0] pdat = 0;
   logic [7:0] ppri = 0;
   logic       pready;
   logic [7:0] vld;
   logic [7:0] rdy = 0;
   logic [7:0] dat [8];
   logic [7:0] pri [8];
   logic [15:0] drop;
   logic       busy;
   logic [15:0] expq [8][$];
   int tests = 0;
   int fails = 0;

   sched_src_queue dut (
      .clk(clk), .reset_n(reset_n), .push_i(push), .push_ch_i(pch),
      .push_data_i(pdat), .push_prio_i(ppri), .push_ready_o(pready),
      .valid_o_0(vld[0]), .valid_o_1(vld[1]), .valid_o_2(vld[2]), .valid_o_3(vld[3]),
      .valid_o_4(vld[4]), .valid_o_5(vld[5]), .valid_o_6(vld[6]), .valid_o_7(vld[7]),
      .data_o_0(dat[0]), .data_o_1(dat[1]), .data_o_2(dat[2]), .data_o_3(dat[3]),
      .data_o_4(dat[4]), .data_o_5(dat[5]), .data_o_6(dat[6]), .data_o_7(dat[7]),
      .priority_o_0(pri[0]), .priority_o_1(pri[1]), .priority_o_2(pri[2]), .priority_o_3(pri[3]),
      .priority_o_4(pri[4]), .priority_o_5(pri[5]), .priority_o_6(pri[6]), .priority_o_7(pri[7]),
      .ready_i_0(rdy[0]), .ready_i_1(rdy[1]), .ready_i_2(rdy[2]), .ready_i_3(rdy[3]),
      .ready_i_4(rdy[4]), .ready_i_5(rdy[5]), .ready_i_6(rdy[6]), .ready_i_7(rdy[7]),
      .drop_cnt_o(drop), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic [2:0] c, input logic [7:0] d, input logic [7:0] p, input bit accept);
      push = 1;
      pch = c;
      pdat = d;
      ppri = p;
      if (accept) expq[c].push_back({d, p});
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         for (int c = 0; c < 8; c++) begin
            if (vld[c] && rdy[c]) begin
               tests++;
               if (expq[c].size() == 0) begin
                  fails++;
                  $display("FAIL pop_ch%0d: got %0h with no entry expected", c, {dat[c], pri[c]});
               end else begin
                  if ({dat[c], pri[c]} != expq[c][0]) begin
                     fails++;
                     $display("FAIL pop_ch%0d: got %0h expected %0h", c, {dat[c], pri[c]}, expq[c][0]);
                  end
                  void'(expq[c].pop_front());
               end
            end
         end
      end
   end

   initial begin
      #12 reset_n = 1;
      tick();
      check("init_busy", busy, 0);
      check("init_ready", pready, 1);
      // hold under backpressure
      set_push(3, 8'hA5, 8'h10, 1);
      tick();
      push = 0;
      for (int k = 0; k < 10; k++) begin
         check("hold_valid", vld[3], 1);
         check("hold_data", dat[3], 8'hA5);
         check("hold_prio", pri[3], 8'h10);
         tick();
      end
      rdy[3] = 1;
      tick();
      rdy[3] = 0;
      check("hold_release_valid", vld[3], 0);
      check("hold_release_data", dat[3], 0);
      // fill and drop
      for (int k = 1; k <= 4; k++) begin
         set_push(0, 8'(k), 8'(8'h20 + k), 1);
         check("fill_ready", pready, 1);
         tick();
      end
      push = 0;
      pch = 0;
      #1 check("full_ready", pready, 0);
      set_push(0, 8'h05, 8'h25, 0);
      tick();
      check("drop_one", drop, 1);
      set_push(1, 8'h11, 8'h01, 1);
      check("ch1_ready", pready, 1);
      tick();
      push = 0;
      check("ch1_valid", vld[1], 1);
      rdy[1] = 1;
      tick();
      rdy[1] = 0;
      // streaming drain
      rdy[0] = 1;
      for (int k = 1; k <= 4; k++) begin
         check("stream_valid", vld[0], 1);
         check("stream_data", dat[0], k);
         tick();
      end
      check("stream_empty", vld[0], 0);
      rdy[0] = 0;
      // full with simultaneous pop
      for (int k = 1; k <= 4; k++) begin
         set_push(2, 8'(8'h20 + k), 8'(8'h40 + k), 1);
         tick();
      end
      set_push(2, 8'h99, 8'h99, 0);
      rdy[2] = 1;
      #1 check("fullpop_ready", pready, 0);
      tick();
      push = 0;
      check("fullpop_drop", drop, 2);
      check("fullpop_valid", vld[2], 1);
      check("fullpop_head", dat[2], 8'h22);
      tick();
      tick();
      check("fullpop_last", dat[2], 8'h24);
      tick();
      check("fullpop_empty", vld[2], 0);
      rdy[2] = 0;
      // concurrent channels and wrap
      rdy[5] = 1;
      for (int i = 0; i < 16; i++) begin
         if (i < 8 && i % 2 == 1) set_push(7, 8'(8'h70 + i), 8'(8'h07 + i), 1);
         else set_push(5, 8'(8'h50 + i), 8'(8'h05 + i), 1);
         check("wrap_ready", pready, 1);
         tick();
      end
      push = 0;
      tick();
      check("wrap_drop", drop, 2);
      check("wrap_ch5_empty", vld[5], 0);
      check("wrap_busy", busy, 1);
      rdy[7] = 1;
      for (int k = 0; k < 4; k++) begin
         check("wrap_busy_drain", busy, 1);
         tick();
      end
      check("wrap_idle", busy, 0);
      rdy[5] = 0;
      rdy[7] = 0;
      for (int c = 0; c < 8; c++) check("queue_empty", expq[c].size(), 0);
      // asynchronous reset mid-cycle with data buffered
      set_push(4, 8'h4A, 8'h4B, 0);
      tick();
      set_push(6, 8'h6A, 8'h6B, 0);
      pch = 0;
      push = 0;
      #2 reset_n = 0;
      #1;
      check("rst_valid", vld, 0);
      check("rst_data4", dat[4], 0);
      check("rst_prio4", pri[4], 0);
      check("rst_drop", drop, 0);
      check("rst_busy", busy, 0);
      pch = 4;
      #1 check("rst_ready", pready, 1);
      #3 reset_n = 1;
      @(posedge clk);
      #1;
      set_push(4, 8'h44, 8'h45, 1);
      tick();
      push = 0;
      check("post_rst_valid", vld[4], 1);
      check("post_rst_data", dat[4], 8'h44);
      rdy[4] = 1;
      tick();
      rdy[4] = 0;
      check("post_rst_empty", vld[4], 0);
      check("final_queue4", expq[4].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
